// File: rtl/ipf_psum_collector.sv
// ipf_psum_collector
//   Sits downstream of the IPF product bus. On each valid result beat it adds
//   up the nine 16-bit products of every one of the 8 cubes. It accumulates
//   ACC_N beats per cube into a single partial sum. Each finished group of
//   8 sums is written into a small FIFO. The FIFO drains one sum per cycle
//   over a valid/ready handshake. The module follows IPF's ctrl encoding so
//   that END and HOLD take effect at the same point in both blocks.
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-low reset
//   ctrl       0 END, 1 START, 2 HOLD, 3 no-op
//   res        8 cubes x 9 products x 16 bits; cube k at [144k+143:144k]
//   res_valid  result beat valid (cannot be stalled)
//   o_data     current output sum
//   o_idx      cube index of o_data
//   o_last     o_idx == 7
//   o_valid    o_data valid (FIFO non-empty)
//   o_ready    sink accepts the beat when o_valid & o_ready
//   ovf        sticky: an entry was dropped because the FIFO was full
//   done       high in the DONE state
module ipf_psum_collector #(
  parameter int ACC_N = 8,
  parameter int ACC_W = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ctrl,
  input  logic [1151:0]    res,
  input  logic             res_valid,
  output logic [ACC_W-1:0] o_data,
  output logic [2:0]       o_idx,
  output logic             o_last,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             ovf,
  output logic             done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] CTRL_END   = 2'd0;
  localparam logic [1:0] CTRL_START = 2'd1;
  localparam logic [1:0] CTRL_HOLD  = 2'd2;
  localparam logic [3:0] CNT_LAST   = 4'(ACC_N - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_DONE} state_t;

  state_t             state, state_next;
  logic [3:0]         cnt;
  logic [ACC_W-1:0]   acc      [8];
  logic [ACC_W-1:0]   acc_next [8];
  logic [19:0]        beat_sum [8];
  logic [8*ACC_W-1:0] push_data;
  logic [8*ACC_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               push_req, push_ok, pop, fifo_full;

  // Per-cube sum of the nine products of this beat, plus the running
  // accumulator including that beat. A non-valid beat contributes nothing,
  // so the same acc_next value also serves the short entry flushed on END.
  always_comb begin
    push_data = '0;
    for (int k = 0; k < 8; k++) begin
      beat_sum[k] = '0;
      for (int j = 0; j < 9; j++)
        beat_sum[k] = beat_sum[k] + 20'(res[144*k + 16*j +: 16]);
      acc_next[k] = acc[k] + (res_valid ? ACC_W'(beat_sum[k]) : '0);
      push_data[k*ACC_W +: ACC_W] = acc_next[k];
    end
  end

  // A push is requested either when the last beat of a group arrives, or
  // when END flushes a partially filled group. When the FIFO is full, a pop
  // at the same edge frees a slot, so the push can still be accepted.
  always_comb begin
    push_req = 1'b0;
    if (state == S_ACC) begin
      if (ctrl == CTRL_END)
        push_req = (cnt != 4'd0) || res_valid;
      else if (ctrl != CTRL_HOLD)
        push_req = res_valid && (cnt == CNT_LAST);
    end
  end

  assign fifo_full = (count == CW'(DEPTH));
  assign o_valid   = (count != '0);
  assign pop       = o_valid && o_ready && (o_idx == 3'd7);
  assign push_ok   = push_req && (!fifo_full || pop);
  assign o_data    = mem[rd_ptr][o_idx*ACC_W +: ACC_W];
  assign o_last    = (o_idx == 3'd7);
  assign done      = (state == S_DONE);

  // Next-state logic. DRAIN ends once the FIFO is empty, which also means
  // that no output beat is still pending.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (ctrl == CTRL_START)    state_next = S_ACC;
               else if (ctrl == CTRL_END) state_next = S_DRAIN;
      S_ACC:   if (ctrl == CTRL_HOLD)     state_next = S_IDLE;
               else if (ctrl == CTRL_END) state_next = S_DRAIN;
      S_DRAIN: if (count == '0)           state_next = S_DONE;
      S_DONE:  state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  // State, accumulators, FIFO pointers, output index and the sticky
  // overflow flag. HOLD and END both clear the partial group. On END, the
  // group has already been captured by the push above.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      o_idx  <= '0;
      ovf    <= 1'b0;
      for (int k = 0; k < 8; k++) acc[k] <= '0;
    end else begin
      state <= state_next;
      if (state == S_ACC) begin
        if (ctrl == CTRL_HOLD || ctrl == CTRL_END) begin
          cnt <= '0;
          for (int k = 0; k < 8; k++) acc[k] <= '0;
        end else if (res_valid) begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            for (int k = 0; k < 8; k++) acc[k] <= '0;
          end else begin
            cnt <= cnt + 4'd1;
            for (int k = 0; k < 8; k++) acc[k] <= acc_next[k];
          end
        end
      end
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
      if (o_valid && o_ready) o_idx <= o_idx + 3'd1;
      if (push_req && !push_ok) ovf <= 1'b1;
    end
  end

  // FIFO storage. It needs no reset, because the pointers and the count
  // decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_ipf_psum_collector.sv
// tb_ipf_psum_collector
//   Directed bench for ipf_psum_collector with the default parameters
//   (ACC_N=8, ACC_W=24, DEPTH=4). Inputs are driven 1 ns after the rising
//   edge and outputs are sampled at the same point.
module tb_ipf_psum_collector;

  localparam logic [1:0] C_END = 2'd0, C_START = 2'd1, C_HOLD = 2'd2, C_NOP = 2'd3;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    ctrl;
  logic [1151:0] res;
  logic          res_valid;
  logic [23:0]   o_data;
  logic [2:0]    o_idx;
  logic          o_last, o_valid, o_ready, ovf, done;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_sum [8];

  ipf_psum_collector #(.ACC_N(8), .ACC_W(24), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .res(res), .res_valid(res_valid),
    .o_data(o_data), .o_idx(o_idx), .o_last(o_last), .o_valid(o_valid),
    .o_ready(o_ready), .ovf(ovf), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, actual, actual, expected, expected);
    end
  endtask

  // Drive one cycle of inputs, then move to 1 ns after the next rising edge.
  task automatic applyStimulus(input logic [1:0] c, input logic v);
    ctrl      = c;
    res_valid = v;
    @(posedge clk);
    #1;
  endtask

  // mode 0: every product 1; mode 1: every product 0xFFFF;
  // mode 2: product j of cube k equals k*16+j.
  function automatic logic [1151:0] makeRes(input int mode);
    logic [1151:0] r;
    r = '0;
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 9; j++)
        case (mode)
          0:       r[144*k + 16*j +: 16] = 16'd1;
          1:       r[144*k + 16*j +: 16] = 16'hFFFF;
          default: r[144*k + 16*j +: 16] = 16'(k*16 + j);
        endcase
    return r;
  endfunction

  // Accept one full entry (8 beats) and compare each one against exp_sum.
  task automatic drainEntry(input string tag, input logic rv);
    o_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput({tag, " valid"}, o_valid, 1);
      checkOutput({tag, " data"},  o_data,  exp_sum[i]);
      checkOutput({tag, " idx"},   o_idx,   i);
      checkOutput({tag, " last"},  o_last,  (i == 7));
      applyStimulus(C_NOP, rv);
    end
  endtask

  task automatic doReset();
    rst = 1'b0;
    applyStimulus(C_NOP, 1'b0);
    applyStimulus(C_NOP, 1'b0);
    rst = 1'b1;
  endtask

  initial begin
    int n;
    rst = 1'b0; ctrl = C_NOP; res = '0; res_valid = 1'b0; o_ready = 1'b1;
    @(posedge clk); #1;
    doReset();
    checkOutput("reset o_valid", o_valid, 0);
    checkOutput("reset ovf",     ovf,     0);
    checkOutput("reset done",    done,    0);
    checkOutput("reset o_idx",   o_idx,   0);

    // T1: all products 1, 8 beats, sum 9*8 = 72 per cube
    $display("[TB] T1 unit products");
    res = makeRes(0);
    applyStimulus(C_START, 1'b0);
    for (int b = 0; b < 7; b++) applyStimulus(C_NOP, 1'b1);
    checkOutput("T1 no valid before 8th", o_valid, 0);
    applyStimulus(C_NOP, 1'b1);
    for (int k = 0; k < 8; k++) exp_sum[k] = 24'd72;
    drainEntry("T1", 1'b0);
    checkOutput("T1 empty after", o_valid, 0);

    // T2: all products 0xFFFF -> 8*9*65535 = 4718520
    $display("[TB] T2 max products");
    res = makeRes(1);
    for (int b = 0; b < 8; b++) applyStimulus(C_NOP, 1'b1);
    for (int k = 0; k < 8; k++) exp_sum[k] = 24'h47FFB8;
    drainEntry("T2", 1'b0);

    // T3: five entries into a 4-deep FIFO with the sink stalled
    $display("[TB] T3 overflow");
    res = makeRes(0);
    o_ready = 1'b0;
    for (int b = 0; b < 32; b++) applyStimulus(C_NOP, 1'b1);
    checkOutput("T3 ovf after 4", ovf, 0);
    checkOutput("T3 hold data", o_data, 72);
    checkOutput("T3 hold idx",  o_idx,  0);
    for (int b = 0; b < 8; b++) applyStimulus(C_NOP, 1'b1);
    checkOutput("T3 ovf after 5", ovf, 1);
    o_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 100 && o_valid; c++) begin
      n++;
      applyStimulus(C_NOP, 1'b0);
    end
    checkOutput("T3 output count", n, 32);
    checkOutput("T3 ovf sticky", ovf, 1);
    doReset();
    checkOutput("T3 ovf cleared", ovf, 0);

    // T4: 3 beats discarded by HOLD, then a full group of the pattern
    $display("[TB] T4 hold");
    res = makeRes(2);
    applyStimulus(C_START, 1'b0);
    for (int b = 0; b < 3; b++) applyStimulus(C_NOP, 1'b1);
    applyStimulus(C_HOLD, 1'b0);
    applyStimulus(C_START, 1'b0);
    for (int b = 0; b < 8; b++) applyStimulus(C_NOP, 1'b1);
    for (int k = 0; k < 8; k++) exp_sum[k] = 24'(8 * (144*k + 36));
    drainEntry("T4", 1'b0);

    // T5: 5 beats then END -> short entry, then DONE; later beats ignored
    $display("[TB] T5 end flush");
    for (int b = 0; b < 5; b++) applyStimulus(C_NOP, 1'b1);
    applyStimulus(C_END, 1'b0);
    for (int k = 0; k < 8; k++) exp_sum[k] = 24'(5 * (144*k + 36));
    drainEntry("T5", 1'b1);
    n = 0;
    for (int c = 0; c < 5 && !done; c++) begin
      n++;
      applyStimulus(C_NOP, 1'b1);
    end
    checkOutput("T5 done", done, 1);
    for (int b = 0; b < 10; b++) applyStimulus(C_NOP, 1'b1);
    checkOutput("T5 ignored after END", o_valid, 0);
    checkOutput("T5 done sticky", done, 1);

    // T6: reset in the middle of a drain
    $display("[TB] T6 reset mid-drain");
    doReset();
    res = makeRes(0);
    o_ready = 1'b0;
    applyStimulus(C_START, 1'b0);
    for (int b = 0; b < 8; b++) applyStimulus(C_NOP, 1'b1);
    applyStimulus(C_END, 1'b0);
    o_ready = 1'b1;
    for (int b = 0; b < 3; b++) applyStimulus(C_NOP, 1'b0);
    o_ready = 1'b0;
    checkOutput("T6 valid before", o_valid, 1);
    checkOutput("T6 idx before",   o_idx,   3);
    rst = 1'b0;
    applyStimulus(C_NOP, 1'b0);
    checkOutput("T6 o_valid", o_valid, 0);
    checkOutput("T6 ovf",     ovf,     0);
    checkOutput("T6 done",    done,    0);
    checkOutput("T6 o_idx",   o_idx,   0);
    rst = 1'b1;
    for (int b = 0; b < 8; b++) applyStimulus(C_NOP, 1'b1);
    checkOutput("T6 idle ignores beats", o_valid, 0);
    checkOutput("T6 not done", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
